// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Round-robin arbiter sharing one synchronous single-port RAM among
// req_count requesters. Each access runs IDLE -> ACCESS -> RESP: the
// winner and its payload are captured in IDLE, presented to the RAM in
// ACCESS, and the RAM's registered output is returned with a done pulse
// in RESP.

module ram_port_arbiter #(
    parameter int mem_width  = 12,
    parameter int addr_width = 12,
    parameter int req_count  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [req_count-1:0]            req,
    input  logic [req_count-1:0]            req_we,
    input  logic [addr_width*req_count-1:0] req_addr,
    input  logic [mem_width*req_count-1:0]  req_wdata,
    output logic [req_count-1:0]            gnt,
    output logic [req_count-1:0]            done,
    output logic [mem_width-1:0]            rdata,
    output logic                            busy,
    output logic [addr_width-1:0]           ram_addr,
    output logic [mem_width-1:0]            ram_wdata,
    output logic                            ram_we,
    input  logic [mem_width-1:0]            ram_rdata
);

    localparam int idx_w = (req_count > 1) ? $clog2(req_count) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]            state;
    logic [idx_w-1:0]      winner;
    logic [idx_w-1:0]      last_winner;
    logic [idx_w-1:0]      pick_idx;
    logic [idx_w-1:0]      cand_idx;
    logic                  pick_valid;
    logic                  lat_we;
    logic [addr_width-1:0] lat_addr;
    logic [mem_width-1:0]  lat_wdata;
    logic [req_count-1:0]  winner_onehot;

    logic [addr_width-1:0] addr_slice  [req_count];
    logic [mem_width-1:0]  wdata_slice [req_count];

    // Unpack the flat request buses into one word per requester.
    for (genvar j = 0; j < req_count; j++) begin : g_unpack
        assign addr_slice[j]  = req_addr[(j+1)*addr_width-1 -: addr_width];
        assign wdata_slice[j] = req_wdata[(j+1)*mem_width-1 -: mem_width];
    end

    // Round-robin search: first set req bit upward from last_winner+1, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int i = 1; i <= req_count; i++) begin
            cand_idx = idx_w'((int'(last_winner) + i) % req_count);
            if (!pick_valid && req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Access sequencer: capture winner in IDLE, then step through ACCESS and RESP.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state       <= IDLE;
            last_winner <= idx_w'(req_count - 1);
            winner      <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner      <= pick_idx;
                        last_winner <= pick_idx;
                        lat_we      <= req_we[pick_idx];
                        lat_addr    <= addr_slice[pick_idx];
                        lat_wdata   <= wdata_slice[pick_idx];
                        state       <= ACCESS;
                    end
                end
                ACCESS:  state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode: grants and pulses follow the state and the captured winner.
    always_comb begin
        winner_onehot = {{(req_count-1){1'b0}}, 1'b1} << winner;
        busy          = (state == ACCESS) || (state == RESP);
        gnt           = busy ? winner_onehot : '0;
        done          = (state == RESP) ? winner_onehot : '0;
        rdata         = (state == RESP) ? ram_rdata : '0;
        ram_we        = (state == ACCESS) && lat_we;
        ram_addr      = lat_addr;
        ram_wdata     = lat_wdata;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed scenarios plus a randomized run checked against a cycle-count
// reference model of the arbiter and a shadow copy of RAM contents.

module tb_ram_port_arbiter;

    localparam int MW = 12;
    localparam int AW = 12;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req, req_we;
    logic [AW*N-1:0] req_addr;
    logic [MW*N-1:0] req_wdata;
    logic [N-1:0]  gnt, done;
    logic [MW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wdata;
    logic          ram_we;
    logic [MW-1:0] ram_rdata;

    logic [MW-1:0] mem    [4096];
    logic [MW-1:0] shadow [4096];

    int n_checks;
    int n_pass;

    ram_port_arbiter #(.mem_width(MW), .addr_width(AW), .req_count(N)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .busy(busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Write-first RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int j, input logic we, input logic [AW-1:0] a, input logic [MW-1:0] d);
        req[j] = 1'b1;
        req_we[j] = we;
        req_addr[j*AW +: AW] = a;
        req_wdata[j*MW +: MW] = d;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req = '0;
        req_we = '0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int i = 1; i <= N; i++)
            if (r[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", gnt); else n_pass++;
        n_checks++; if (done !== 4'b0000) $display("FAIL reset_done got=%b exp=0000", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we got=%b exp=0", ram_we); else n_pass++;
        n_checks++; if (ram_addr !== 12'h000) $display("FAIL reset_ram_addr got=%h exp=000", ram_addr); else n_pass++;
        n_checks++; if (ram_wdata !== 12'h000) $display("FAIL reset_ram_wdata got=%h exp=000", ram_wdata); else n_pass++;
        n_checks++; if (rdata !== 12'h000) $display("FAIL reset_rdata got=%h exp=000", rdata); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_single_read;
        do_reset;
        mem[5] = 12'hABC;
        set_req(0, 1'b0, 12'h005, 12'h000);
        tick;
        n_checks++; if (gnt !== 4'b0001) $display("FAIL read_gnt got=%b exp=0001", gnt); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL read_ram_we got=%b exp=0", ram_we); else n_pass++;
        n_checks++; if (ram_addr !== 12'h005) $display("FAIL read_ram_addr got=%h exp=005", ram_addr); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL read_busy got=%b exp=1", busy); else n_pass++;
        n_checks++; if (done !== 4'b0000) $display("FAIL read_early_done got=%b exp=0000", done); else n_pass++;
        tick;
        n_checks++; if (done !== 4'b0001) $display("FAIL read_done got=%b exp=0001", done); else n_pass++;
        n_checks++; if (rdata !== 12'hABC) $display("FAIL read_rdata got=%h exp=abc", rdata); else n_pass++;
        req[0] = 1'b0;
        tick;
        n_checks++; if (gnt !== 4'b0000) $display("FAIL read_after_gnt got=%b exp=0000", gnt); else n_pass++;
        n_checks++; if (rdata !== 12'h000) $display("FAIL read_after_rdata got=%h exp=000", rdata); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL read_after_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_write;
        set_req(2, 1'b1, 12'h3FF, 12'h123);
        tick;
        n_checks++; if (gnt !== 4'b0100) $display("FAIL write_gnt got=%b exp=0100", gnt); else n_pass++;
        n_checks++; if (ram_we !== 1'b1) $display("FAIL write_ram_we got=%b exp=1", ram_we); else n_pass++;
        n_checks++; if (ram_addr !== 12'h3FF) $display("FAIL write_ram_addr got=%h exp=3ff", ram_addr); else n_pass++;
        n_checks++; if (ram_wdata !== 12'h123) $display("FAIL write_ram_wdata got=%h exp=123", ram_wdata); else n_pass++;
        tick;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL write_resp_we got=%b exp=0", ram_we); else n_pass++;
        n_checks++; if (done !== 4'b0100) $display("FAIL write_done got=%b exp=0100", done); else n_pass++;
        n_checks++; if (rdata !== 12'h123) $display("FAIL write_rdata got=%h exp=123", rdata); else n_pass++;
        req[2] = 1'b0;
        req_we[2] = 1'b0;
        tick;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL write_idle_we got=%b exp=0", ram_we); else n_pass++;
        n_checks++; if (ram_addr !== 12'h3FF) $display("FAIL write_hold_addr got=%h exp=3ff", ram_addr); else n_pass++;
        n_checks++; if (ram_wdata !== 12'h123) $display("FAIL write_hold_wdata got=%h exp=123", ram_wdata); else n_pass++;
    endtask

    task automatic test_contention;
        logic [N-1:0] exp_gnt;
        int k, phase;
        do_reset;
        for (int j = 0; j < N; j++) set_req(j, 1'b0, AW'(12'h020 + j), 12'h000);
        for (int c = 1; c <= 12; c++) begin
            tick;
            k = (c - 1) / 3;
            phase = (c - 1) % 3;
            exp_gnt = (phase < 2) ? (N'(1) << k) : '0;
            n_checks++; if (gnt !== exp_gnt) $display("FAIL contend_gnt cycle=%0d got=%b exp=%b", c, gnt, exp_gnt); else n_pass++;
            n_checks++; if ($countones(gnt) > 1) $display("FAIL contend_onehot cycle=%0d got=%b", c, gnt); else n_pass++;
            if (phase == 0) begin
                n_checks++; if (ram_addr !== AW'(12'h020 + k)) $display("FAIL contend_addr cycle=%0d got=%h exp=%h", c, ram_addr, AW'(12'h020 + k)); else n_pass++;
            end
            if (phase == 1) req[k] = 1'b0;
        end
    endtask

    task automatic test_wrap;
        set_req(0, 1'b0, 12'h030, 12'h000);
        set_req(3, 1'b0, 12'h033, 12'h000);
        tick;
        n_checks++; if (gnt !== 4'b0001) $display("FAIL wrap_first got=%b exp=0001", gnt); else n_pass++;
        tick;
        n_checks++; if (done !== 4'b0001) $display("FAIL wrap_first_done got=%b exp=0001", done); else n_pass++;
        req[0] = 1'b0;
        tick;
        tick;
        n_checks++; if (gnt !== 4'b1000) $display("FAIL wrap_second got=%b exp=1000", gnt); else n_pass++;
        tick;
        n_checks++; if (done !== 4'b1000) $display("FAIL wrap_second_done got=%b exp=1000", done); else n_pass++;
        req[3] = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        set_req(1, 1'b1, 12'h041, 12'h777);
        tick;
        n_checks++; if (ram_we !== 1'b1) $display("FAIL mid_access_we got=%b exp=1", ram_we); else n_pass++;
        reset = 1'b1;
        tick;
        n_checks++; if (done !== 4'b0000) $display("FAIL mid_done got=%b exp=0000", done); else n_pass++;
        n_checks++; if (gnt !== 4'b0000) $display("FAIL mid_gnt got=%b exp=0000", gnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL mid_ram_we got=%b exp=0", ram_we); else n_pass++;
        n_checks++; if (ram_addr !== 12'h000) $display("FAIL mid_ram_addr got=%h exp=000", ram_addr); else n_pass++;
        reset = 1'b0;
        req = '0;
        req_we = '0;
        set_req(3, 1'b0, 12'h043, 12'h000);
        tick;
        n_checks++; if (gnt !== 4'b1000) $display("FAIL mid_regrant got=%b exp=1000", gnt); else n_pass++;
        n_checks++; if (ram_addr !== 12'h043) $display("FAIL mid_regrant_addr got=%h exp=043", ram_addr); else n_pass++;
        tick;
        n_checks++; if (done !== 4'b1000) $display("FAIL mid_regrant_done got=%b exp=1000", done); else n_pass++;
        req[3] = 1'b0;
        tick;
    endtask

    task automatic test_idle;
        req = '0;
        for (int c = 0; c < 20; c++) begin
            tick;
            n_checks++; if (gnt !== 4'b0000) $display("FAIL idle_gnt cycle=%0d got=%b", c, gnt); else n_pass++;
            n_checks++; if (done !== 4'b0000) $display("FAIL idle_done cycle=%0d got=%b", c, done); else n_pass++;
            n_checks++; if (ram_we !== 1'b0) $display("FAIL idle_ram_we cycle=%0d got=%b", c, ram_we); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy cycle=%0d got=%b", c, busy); else n_pass++;
        end
    endtask

    task automatic test_random;
        int last, win, grant_at, free_at;
        logic in_acc, in_resp, e_we;
        logic [AW-1:0] e_addr;
        logic [MW-1:0] e_wdata, e_rdata, exp_rdata;
        logic [N-1:0] exp_gnt, exp_done;
        do_reset;
        last = N - 1;
        win = 0;
        grant_at = -10;
        free_at = 0;
        e_we = 1'b0;
        e_addr = '0;
        e_wdata = '0;
        e_rdata = '0;
        for (int c = 0; c < 600; c++) begin
            in_acc = (c == grant_at);
            in_resp = (c == grant_at + 1);
            exp_gnt = (in_acc || in_resp) ? (N'(1) << win) : '0;
            exp_done = in_resp ? (N'(1) << win) : '0;
            exp_rdata = in_resp ? e_rdata : '0;
            n_checks++; if (gnt !== exp_gnt) $display("FAIL rand_gnt cycle=%0d got=%b exp=%b", c, gnt, exp_gnt); else n_pass++;
            n_checks++; if (done !== exp_done) $display("FAIL rand_done cycle=%0d got=%b exp=%b", c, done, exp_done); else n_pass++;
            n_checks++; if (busy !== (in_acc || in_resp)) $display("FAIL rand_busy cycle=%0d got=%b exp=%b", c, busy, in_acc || in_resp); else n_pass++;
            n_checks++; if (ram_we !== (in_acc && e_we)) $display("FAIL rand_ram_we cycle=%0d got=%b exp=%b", c, ram_we, in_acc && e_we); else n_pass++;
            n_checks++; if (rdata !== exp_rdata) $display("FAIL rand_rdata cycle=%0d got=%h exp=%h", c, rdata, exp_rdata); else n_pass++;
            n_checks++; if (ram_addr !== e_addr) $display("FAIL rand_ram_addr cycle=%0d got=%h exp=%h", c, ram_addr, e_addr); else n_pass++;
            n_checks++; if (ram_wdata !== e_wdata) $display("FAIL rand_ram_wdata cycle=%0d got=%h exp=%h", c, ram_wdata, e_wdata); else n_pass++;

            // Requesters: owner drops after done; others may raise or withdraw.
            for (int j = 0; j < N; j++) begin
                if (in_resp && j == win)
                    req[j] = 1'b0;
                else if (!req[j]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(j, 1'($urandom_range(0, 1)), AW'(12'h100 + $urandom_range(0, 15)), MW'($urandom));
                end else if (!(c < free_at && j == win) && $urandom_range(0, 9) == 0)
                    req[j] = 1'b0;
            end

            // Arbiter free this cycle: the round-robin winner starts an access.
            if (c >= free_at && req != '0) begin
                win = rr_pick(last, req);
                last = win;
                grant_at = c + 1;
                free_at = c + 3;
                e_we = req_we[win];
                e_addr = req_addr[win*AW +: AW];
                e_wdata = req_wdata[win*MW +: MW];
                e_rdata = e_we ? e_wdata : shadow[e_addr];
                if (e_we) shadow[e_addr] = e_wdata;
            end
            tick;
        end
        req = '0;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        reset = 1'b1;
        req = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = MW'($urandom);
            shadow[i] = mem[i];
        end
        test_reset;
        test_single_read;
        test_write;
        test_contention;
        test_wrap;
        test_reset_mid;
        test_idle;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
